// File: rtl/mem_port_arbiter.sv
// Purpose : shares one data-memory BRAM port between the exec memory unit (r0) and the loader/debug port (r1).
// Latency : accept is combinational in the order cycle; done follows exactly READ_LAT cycles later.
// Backpressure: the loser of a round-robin grant sees accepted=0 and holds its order and operands.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   rN_order/rN_accepted/rN_done  per-requester handshake (N = 0, 1)
//   rN_addr/rN_sd/rN_write/rN_ld  per-requester word address, store data, byte enables (0 = load), load data
//   mem_a/mem_sd/mem_write/mem_en BRAM command side; mem_ld is the BRAM read data (valid READ_LAT after mem_en)
module mem_port_arbiter #(
    parameter int ADDR_W   = 17,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 2      // legal range 1..4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              r0_order,
    output logic              r0_accepted,
    output logic              r0_done,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_sd,
    input  logic [3:0]        r0_write,
    output logic [DATA_W-1:0] r0_ld,

    input  logic              r1_order,
    output logic              r1_accepted,
    output logic              r1_done,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_sd,
    input  logic [3:0]        r1_write,
    output logic [DATA_W-1:0] r1_ld,

    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_sd,
    input  logic [DATA_W-1:0] mem_ld,
    output logic [3:0]        mem_write,
    output logic              mem_en
);

    // rr_ptr names the requester that wins when both order (0 or 1).
    logic                rr_ptr;
    logic                grant0;
    logic                grant1;
    logic                grant;

    // Registered mirror of the last granted address/data, driven while idle.
    logic [ADDR_W-1:0]   a_q;
    logic [DATA_W-1:0]   sd_q;

    // Tag pipeline: one {valid, owner} pair per BRAM read stage.
    logic [READ_LAT-1:0] tag_vld;
    logic [READ_LAT-1:0] tag_own;

    logic [DATA_W-1:0]   ld0_q;
    logic [DATA_W-1:0]   ld1_q;

    always_comb begin
        grant0 = !rst && r0_order && (!r1_order || !rr_ptr);
        grant1 = !rst && r1_order && (!r0_order ||  rr_ptr);
        grant  = grant0 || grant1;
    end

    assign r0_accepted = grant0;
    assign r1_accepted = grant1;

    always_comb begin
        mem_en    = grant;
        mem_write = 4'b0000;
        mem_a     = a_q;
        mem_sd    = sd_q;
        if (grant0) begin
            mem_write = r0_write;
            mem_a     = r0_addr;
            mem_sd    = r0_sd;
        end else if (grant1) begin
            mem_write = r1_write;
            mem_a     = r1_addr;
            mem_sd    = r1_sd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr  <= 1'b0;
            tag_vld <= '0;
            tag_own <= '0;
            a_q     <= '0;
            sd_q    <= '0;
        end else begin
            // Winner loses priority; the other requester is favoured next.
            if (grant) begin
                rr_ptr <= grant0;
                a_q    <= mem_a;
                sd_q   <= mem_sd;
            end
            // Shift every cycle with no stall: BRAM latency is fixed.
            for (int i = READ_LAT - 1; i > 0; i--) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_own[i] <= tag_own[i-1];
            end
            tag_vld[0] <= grant;
            tag_own[0] <= grant1;
        end
    end

    // Dones are suppressed while reset is held so in-flight tags vanish silently.
    assign r0_done = !rst && tag_vld[READ_LAT-1] && !tag_own[READ_LAT-1];
    assign r1_done = !rst && tag_vld[READ_LAT-1] &&  tag_own[READ_LAT-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            ld0_q <= '0;
            ld1_q <= '0;
        end else begin
            if (r0_done) ld0_q <= mem_ld;
            if (r1_done) ld1_q <= mem_ld;
        end
    end

    // Load data is live in the done cycle and held afterwards.
    assign r0_ld = r0_done ? mem_ld : ld0_q;
    assign r1_ld = r1_done ? mem_ld : ld1_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose : directed self-checking bench for mem_port_arbiter with a two-stage BRAM model.
// Latency : BRAM model returns read data READ_LAT=2 cycles after mem_en.
// Backpressure: requesters hold order/operands until accepted.
module tb_mem_port_arbiter;

    localparam int ADDR_W   = 17;
    localparam int DATA_W   = 32;
    localparam int READ_LAT = 2;

    logic              clk;
    logic              rst;
    logic              r0_order, r0_accepted, r0_done;
    logic [ADDR_W-1:0] r0_addr;
    logic [DATA_W-1:0] r0_sd, r0_ld;
    logic [3:0]        r0_write;
    logic              r1_order, r1_accepted, r1_done;
    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_sd, r1_ld;
    logic [3:0]        r1_write;
    logic [ADDR_W-1:0] mem_a;
    logic [DATA_W-1:0] mem_sd, mem_ld;
    logic [3:0]        mem_write;
    logic              mem_en;

    int n_chk;
    int n_err;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(READ_LAT)) dut (
        .clk(clk), .rst(rst),
        .r0_order(r0_order), .r0_accepted(r0_accepted), .r0_done(r0_done),
        .r0_addr(r0_addr), .r0_sd(r0_sd), .r0_write(r0_write), .r0_ld(r0_ld),
        .r1_order(r1_order), .r1_accepted(r1_accepted), .r1_done(r1_done),
        .r1_addr(r1_addr), .r1_sd(r1_sd), .r1_write(r1_write), .r1_ld(r1_ld),
        .mem_a(mem_a), .mem_sd(mem_sd), .mem_ld(mem_ld),
        .mem_write(mem_write), .mem_en(mem_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Small BRAM model: 256 words, byte writes, two registered read stages.
    logic [DATA_W-1:0] bram [0:255];
    logic [DATA_W-1:0] rd_s0, rd_s1;

    always @(posedge clk) begin
        if (mem_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_write[b]) bram[mem_a[7:0]][8*b +: 8] <= mem_sd[8*b +: 8];
            rd_s0 <= bram[mem_a[7:0]];
        end
        rd_s1 <= rd_s0;
    end
    assign mem_ld = rd_s1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle_in();
        r0_order = 1'b0; r1_order = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_in();
        nxt();
        smp();
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_mem_write", mem_write, 4'h0);
        nxt();
        rst = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        for (int i = 0; i < 256; i++) bram[i] = 32'hA500_0000 | i;
        rd_s0 = '0; rd_s1 = '0;
        rst = 1'b1;
        r0_order = 0; r0_addr = '0; r0_sd = '0; r0_write = 4'h0;
        r1_order = 0; r1_addr = '0; r1_sd = '0; r1_write = 4'h0;
        nxt();
        do_reset();

        // Cycle after reset: everything quiet.
        smp();
        chk("post_rst_r0_done", r0_done, 1'b0);
        chk("post_rst_r1_done", r1_done, 1'b0);
        chk("post_rst_r0_acc", r0_accepted, 1'b0);

        // 1) r0 load 0x10 alone.
        nxt();
        r0_order = 1; r0_addr = 17'h10; r0_write = 4'h0;
        smp();
        chk("t1_r0_acc", r0_accepted, 1'b1);
        chk("t1_r1_acc", r1_accepted, 1'b0);
        chk("t1_mem_en", mem_en, 1'b1);
        chk("t1_mem_a", mem_a, 17'h10);
        nxt(); r0_order = 0;
        smp();
        chk("t1_r0_done_early", r0_done, 1'b0);
        nxt();
        smp();
        chk("t1_r0_done", r0_done, 1'b1);
        chk("t1_r0_ld", r0_ld, 32'hA500_0010);
        chk("t1_r1_done", r1_done, 1'b0);
        nxt();
        smp();
        chk("t1_r0_done_after", r0_done, 1'b0);
        chk("t1_r0_ld_hold", r0_ld, 32'hA500_0010);
        chk("t1_idle_en", mem_en, 1'b0);
        chk("t1_idle_a", mem_a, 17'h10);

        // 2) r1 store 0x20, then r0 load 0x20.
        nxt();
        r1_order = 1; r1_addr = 17'h20; r1_sd = 32'hDEAD_BEEF; r1_write = 4'hF;
        smp();
        chk("t2_r1_acc", r1_accepted, 1'b1);
        chk("t2_mem_write", mem_write, 4'hF);
        chk("t2_mem_sd", mem_sd, 32'hDEAD_BEEF);
        nxt();
        r1_order = 0; r1_write = 4'h0;
        r0_order = 1; r0_addr = 17'h20; r0_write = 4'h0;
        smp();
        chk("t2_r0_acc", r0_accepted, 1'b1);
        nxt(); r0_order = 0;
        smp();
        chk("t2_r1_done", r1_done, 1'b1);
        chk("t2_r0_done_early", r0_done, 1'b0);
        nxt();
        smp();
        chk("t2_r0_done", r0_done, 1'b1);
        chk("t2_r0_ld", r0_ld, 32'hDEAD_BEEF);
        chk("t2_r1_done_after", r1_done, 1'b0);

        // 3) Continuous contention after reset: 0,1,0,1,0,1.
        nxt();
        do_reset();
        r0_addr = 17'h30; r1_addr = 17'h31;
        for (int k = 0; k < 8; k++) begin
            r0_order = (k < 6); r1_order = (k < 6);
            smp();
            if (k < 6) begin
                chk($sformatf("t3_r0_acc_%0d", k), r0_accepted, (k % 2) == 0);
                chk($sformatf("t3_r1_acc_%0d", k), r1_accepted, (k % 2) == 1);
            end
            if (k >= 2) begin
                chk($sformatf("t3_r0_done_%0d", k), r0_done, (k % 2) == 0);
                chk($sformatf("t3_r1_done_%0d", k), r1_done, (k % 2) == 1);
                if (k % 2 == 0) chk($sformatf("t3_r0_ld_%0d", k), r0_ld, 32'hA500_0030);
                else            chk($sformatf("t3_r1_ld_%0d", k), r1_ld, 32'hA500_0031);
            end else begin
                chk($sformatf("t3_nodone_%0d", k), {r0_done, r1_done}, 2'b00);
            end
            nxt();
        end
        idle_in();

        // 4) r1 alone three times, then both: r0 then r1.
        for (int k = 0; k < 5; k++) begin
            r1_order = 1; r0_order = (k >= 3);
            smp();
            chk($sformatf("t4_r0_acc_%0d", k), r0_accepted, k == 3);
            chk($sformatf("t4_r1_acc_%0d", k), r1_accepted, k != 3);
            nxt();
        end
        idle_in();
        nxt(); nxt(); nxt();

        // 5) Grant, then reset next cycle: tag dropped, rr_ptr back to 0.
        r0_order = 1; r0_addr = 17'h40;
        smp();
        chk("t5_r0_acc", r0_accepted, 1'b1);
        nxt();
        r0_order = 0; rst = 1;
        smp();
        chk("t5_nodone_0", {r0_done, r1_done}, 2'b00);
        nxt();
        rst = 0;
        smp();
        chk("t5_nodone_1", {r0_done, r1_done}, 2'b00);
        nxt();
        smp();
        chk("t5_nodone_2", {r0_done, r1_done}, 2'b00);
        nxt();
        r0_order = 1; r1_order = 1; r0_addr = 17'h44; r1_addr = 17'h55;
        smp();
        chk("t5_rr_r0_acc", r0_accepted, 1'b1);
        chk("t5_rr_r1_acc", r1_accepted, 1'b0);
        nxt();

        // 6) Idle with stray operands: port quiet, address held.
        idle_in();
        r1_write = 4'hF; r1_addr = 17'h77;
        for (int k = 0; k < 3; k++) begin
            smp();
            chk($sformatf("t6_en_%0d", k), mem_en, 1'b0);
            chk($sformatf("t6_wr_%0d", k), mem_write, 4'h0);
            chk($sformatf("t6_a_%0d", k), mem_a, 17'h44);
            nxt();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single data-memory BRAM port between two requesters: requester 0 is the exec memory unit, requester 1 is the program/data loader or debug port.
- Uses the core's order/accepted/done handshake on each side.
- Grants at most one access per cycle with round-robin priority.
- Tracks in-flight accesses in a tag pipeline so each done and load data go back to the correct owner.

Parameters:
- ADDR_W, 17, width of the BRAM word address (matches LEN_MEMDATA_ADDR).
- DATA_W, 32, word width.
- READ_LAT, 2, BRAM cycles from mem_en to valid mem_ld; legal range 1..4.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- r0_order  in  1  requester 0 request valid; held by the requester until accepted
- r0_accepted  out  1  request taken this cycle (combinational)
- r0_done  out  1  access completed; r0_ld valid this cycle
- r0_addr  in  ADDR_W  word address
- r0_sd  in  DATA_W  store data
- r0_write  in  4  byte write enables; 0 means load
- r0_ld  out  DATA_W  load data
- r1_order, r1_accepted, r1_done, r1_addr, r1_sd, r1_write, r1_ld  same as requester 0
- mem_a  out  ADDR_W  BRAM address
- mem_sd  out  DATA_W  BRAM write data
- mem_ld  in  DATA_W  BRAM read data
- mem_write  out  4  BRAM byte write enables
- mem_en  out  1  BRAM enable

Behaviour:
- Reset:
  - rr_ptr=0 (requester 0 favoured).
  - Tag pipeline cleared.
  - All done/accepted outputs 0 in the cycle after reset.
  - mem_en=0 and mem_write=0 while rst is high.
- Grant (combinational, same cycle as order):
  - Only one requester ordering: grant it.
  - Both ordering: grant the requester selected by rr_ptr.
  - Neither ordering: mem_en=0, mem_write=0, mem_a and mem_sd hold their last granted values (registered mirror).
- Grant side effects:
  - rN_accepted=1 for the winner.
  - mem_en=1; mem_a, mem_sd, mem_write driven from the winner.
  - The loser sees accepted=0 and must hold its order and operands.
- rr_ptr update:
  - On any grant, rr_ptr becomes the non-winner at the next edge.
  - With no grant, rr_ptr holds.
- Tag pipeline:
  - READ_LAT stages, each holding {valid, owner}.
  - Stage 0 is loaded at grant; the pipeline shifts every cycle with no stall.
- Completion:
  - Stage READ_LAT-1 valid with owner N → rN_done=1 that cycle.
  - rN_ld = mem_ld in the done cycle; outside done cycles rN_ld holds the last delivered value (registered).
  - Latency: done exactly READ_LAT cycles after the accept cycle, for both loads and stores.
  - Stores return done with rN_ld undefined-but-stable; benches do not check it.
- Throughput and ordering:
  - One grant per cycle; back-to-back grants are legal.
  - Up to READ_LAT accesses in flight.
  - Completion order equals grant order.
- Simultaneous events:
  - A done for one requester and an accept for the same requester in the same cycle are independent and both assert.
- Reset mid-operation:
  - All in-flight tags are dropped; no done is issued for them.
  - A BRAM write already presented before reset still lands.
- Fairness: continuous contention strictly alternates grants 0,1,0,1,…; no starvation.
- Store data passes through untouched: no byte shifting.

Test Plan:
- Reset, then r0 load addr=0x10 alone, READ_LAT=2 → r0_accepted in cycle T, mem_en=1, mem_a=0x10; r0_done at T+2 with r0_ld = BRAM[0x10]; r1_done stays 0.
- r1 store addr=0x20, data=0xDEADBEEF, write=4'b1111, then r0 load 0x20 next cycle → r1_done at T+2, r0_done at T+3 with r0_ld=0xDEADBEEF.
- Both ordering continuously for 6 cycles, first grant after reset → grants 0,1,0,1,0,1; dones follow at +2 with matching owners.
- r1 ordering alone for 3 cycles, then both → r1 granted 3 times, then r0 (rr_ptr=0 after the r1 grants), then r1.
- Grant issued, rst asserted the next cycle → no rN_done in the following 3 cycles; rr_ptr=0 afterwards.
- Idle cycles → mem_en=0 and mem_write=0 every cycle; mem_a holds the last granted address.
